sdram_dl_writer: RTL and testbench

- Requester-side master for one toggle-handshake port (req/ack/we/a/ds/d) of the two-bank interleaved SDRAM controller.
- Converts the byte-wide ROM download stream (dl_wr/dl_addr/dl_data) into 16-bit SDRAM write requests.
- Merges adjacent byte pairs into words, buffers completed words in a small FIFO and back-pressures the download source.
- Sits between the data_io download logic and the controller's port1/port2 request inputs.

---
 rtl/sdram_dl_writer.sv | 206 ++++++++++++++++++++
 tb/tb_sdram_dl_writer.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_dl_writer.sv
// Turns the byte-wide ROM download stream into 16-bit toggle-handshake SDRAM
// write requests, pairing bytes into words and buffering them in a small FIFO.
`timescale 1ns/1ps
module sdram_dl_writer #(
    parameter int unsigned DEPTH = 4,
    parameter logic [23:0] BASE  = 24'h000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [23:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic        dl_wait,
    output logic        port_req,
    input  logic        port_ack,
    output logic        port_we,
    output logic [22:0] port_a,
    output logic [1:0]  port_ds,
    output logic [15:0] port_d,
    output logic        done,
    output logic [23:0] words_written
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
    } entry_t;

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} dl_state_t;
    typedef enum logic {REQ_IDLE, REQ_BUSY} req_state_t;

    dl_state_t        dl_state;
    req_state_t       req_state;
    entry_t           fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             held_valid;
    logic             held_odd;
    logic [22:0]      held_wa;
    logic [7:0]       held_data;
    logic             dl_active_q;

    logic [23:0]      eff_addr;
    logic             strobe;
    logic             full;
    logic             empty;
    logic             pop;
    logic             push_req;
    logic             do_push;
    logic             hold_set;
    logic             hold_clr;
    entry_t           push_entry;
    entry_t           held_entry;
    entry_t           head;

    assign port_we  = 1'b1;
    assign eff_addr = dl_addr + BASE;
    assign strobe   = dl_wr && dl_active;
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop      = (req_state == REQ_BUSY) && (port_ack == port_req);
    assign do_push  = push_req && !full;
    assign head     = fifo_mem[rd_ptr];

    // Byte assembly: a held odd byte never pairs, it is flushed on the next quiet cycle.
    always_comb begin
        held_entry = '{a: held_wa,
                       ds: held_odd ? 2'b10 : 2'b01,
                       d: held_odd ? {held_data, 8'h00} : {8'h00, held_data}};
        push_req   = 1'b0;
        push_entry = held_entry;
        hold_set   = 1'b0;
        hold_clr   = 1'b0;
        if (strobe) begin
            if (held_valid && !held_odd && eff_addr[0] && (held_wa == eff_addr[23:1])) begin
                push_req   = 1'b1;
                push_entry = '{a: eff_addr[23:1], ds: 2'b11, d: {dl_data, held_data}};
                hold_clr   = 1'b1;
            end else if (held_valid) begin
                push_req = 1'b1;
                hold_set = 1'b1;
            end else if (eff_addr[0]) begin
                push_req   = 1'b1;
                push_entry = '{a: eff_addr[23:1], ds: 2'b10, d: {dl_data, 8'h00}};
            end else begin
                hold_set = 1'b1;
            end
        end else if (held_valid && (held_odd || !dl_active) && !full) begin
            push_req = 1'b1;
            hold_clr = 1'b1;
        end
    end

    always_comb begin
        count_nxt = count;
        if (do_push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (!do_push && pop) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dl_state      <= IDLE;
            req_state     <= REQ_IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            held_valid    <= 1'b0;
            held_odd      <= 1'b0;
            held_wa       <= '0;
            held_data     <= '0;
            dl_active_q   <= 1'b0;
            dl_wait       <= 1'b0;
            port_req      <= port_ack;
            port_a        <= '0;
            port_ds       <= '0;
            port_d        <= '0;
            done          <= 1'b0;
            words_written <= '0;
        end else begin
            dl_active_q <= dl_active;
            count       <= count_nxt;
            dl_wait     <= (count_nxt >= CNT_W'(DEPTH - 1));
            done        <= 1'b0;
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (hold_set) begin
                held_valid <= 1'b1;
                held_odd   <= eff_addr[0];
                held_wa    <= eff_addr[23:1];
                held_data  <= dl_data;
            end else if (hold_clr) begin
                held_valid <= 1'b0;
            end

            // Requester: idle port_req tracks port_ack so stale acks cannot complete anything.
            case (req_state)
                REQ_IDLE: begin
                    if (!empty) begin
                        port_a    <= head.a;
                        port_ds   <= head.ds;
                        port_d    <= head.d;
                        port_req  <= ~port_ack;
                        req_state <= REQ_BUSY;
                    end else begin
                        port_req <= port_ack;
                    end
                end
                REQ_BUSY: begin
                    if (pop) begin
                        words_written <= words_written + 24'd1;
                        req_state     <= REQ_IDLE;
                    end
                end
                default: req_state <= REQ_IDLE;
            endcase

            case (dl_state)
                IDLE: begin
                    if (dl_active && !dl_active_q) begin
                        words_written <= '0;
                        dl_state      <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (!dl_active) begin
                        dl_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (empty && !held_valid && (req_state == REQ_IDLE)) begin
                        if (dl_active) begin
                            dl_state <= ACTIVE;
                        end else begin
                            done     <= 1'b1;
                            dl_state <= IDLE;
                        end
                    end
                end
                default: dl_state <= IDLE;
            endcase
        end
    end

    // The source must honour dl_wait; a push into a full FIFO loses data.
    assert property (@(posedge clk) disable iff (reset) !(push_req && full));

endmodule

// File: tb/tb_sdram_dl_writer.sv
// Scoreboard bench for sdram_dl_writer: byte downloads in, expected SDRAM
// write requests queued at stimulus time and matched on each port_req toggle.
`timescale 1ns/1ps
module tb_sdram_dl_writer;
    typedef struct packed {
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dl_active = 1'b0;
    logic        dl_wr = 1'b0;
    logic [23:0] dl_addr = '0;
    logic [7:0]  dl_data = '0;
    logic        dl_wait;
    logic        port_req;
    logic        port_ack;
    logic        port_we;
    logic [22:0] port_a;
    logic [1:0]  port_ds;
    logic [15:0] port_d;
    logic        done;
    logic [23:0] words_written;

    logic        b_wait, b_req, b_we, b_done;
    logic        b_ack = 1'b0;
    logic [22:0] b_a;
    logic [1:0]  b_ds;
    logic [15:0] b_d;
    logic [23:0] b_ww;

    logic        ack_reg = 1'b0;
    logic        ack_flip = 1'b0;
    logic        ack_hold = 1'b0;
    int          ack_cnt = 0;
    localparam int ACK_DLY = 7;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          req_seen = 0;
    int          toggles = 0;
    int          done_cnt = 0;
    logic        last_req = 1'b0;
    logic        b_last_req = 1'b0;
    int          b_reqs = 0;
    logic [22:0] b_last_a = '0;
    logic [15:0] b_last_d = '0;

    assign port_ack = ack_reg ^ ack_flip;

    sdram_dl_writer #(.DEPTH(4), .BASE(24'h000000)) u_dut (
        .clk(clk), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(dl_wait),
        .port_req(port_req), .port_ack(port_ack), .port_we(port_we),
        .port_a(port_a), .port_ds(port_ds), .port_d(port_d),
        .done(done), .words_written(words_written)
    );

    sdram_dl_writer #(.DEPTH(4), .BASE(24'h100000)) u_base (
        .clk(clk), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(b_wait),
        .port_req(b_req), .port_ack(b_ack), .port_we(b_we),
        .port_a(b_a), .port_ds(b_ds), .port_d(b_d),
        .done(b_done), .words_written(b_ww)
    );

    always #5 clk = ~clk;

    // Controller model: acknowledge an outstanding request ACK_DLY cycles later.
    always @(posedge clk) begin
        if (reset || ack_hold || port_req == port_ack) begin
            ack_cnt <= 0;
        end else if (ack_cnt >= ACK_DLY - 1) begin
            ack_reg <= ~ack_reg;
            ack_cnt <= 0;
        end else begin
            ack_cnt <= ack_cnt + 1;
        end
    end

    always @(posedge clk) b_ack <= b_req;

    // Request monitor: a new request is a port_req change that leaves req != ack.
    always @(negedge clk) begin
        if (!reset && port_req !== last_req) begin
            toggles++;
            if (port_req !== port_ack) begin
                exp_t e;
                logic [15:0] m;
                req_seen++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL request: unexpected a=%h ds=%b d=%h", port_a, port_ds, port_d);
                end else begin
                    e = exp_q.pop_front();
                    m = {{8{e.ds[1]}}, {8{e.ds[0]}}};
                    if (port_a !== e.a || port_ds !== e.ds || (port_d & m) !== e.d) begin
                        n_errors++;
                        $display("FAIL request: got a=%h ds=%b d=%h, required a=%h ds=%b d=%h",
                                 port_a, port_ds, port_d, e.a, e.ds, e.d);
                    end
                end
            end
        end
        if (!reset && done === 1'b1) done_cnt++;
        if (!reset && b_req !== b_last_req && b_req !== b_ack) begin
            b_reqs++;
            b_last_a = b_a;
            b_last_d = b_d;
        end
        last_req   = port_req;
        b_last_req = b_req;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input logic [22:0] a, input logic [1:0] ds, input logic [15:0] d);
        exp_t e;
        e.a = a;
        e.ds = ds;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [23:0] addr, input logic [7:0] data);
        int guard;
        guard = 0;
        while (dl_wait === 1'b1 && guard < 400) begin
            tick(1);
            guard++;
        end
        n_checks++;
        if (guard >= 400) begin
            n_errors++;
            $display("FAIL send_byte: dl_wait stuck at %b, required 0", dl_wait);
        end
        dl_addr = addr;
        dl_data = data;
        dl_wr   = 1'b1;
        tick(1);
        dl_wr   = 1'b0;
    endtask

    task automatic start_dl();
        dl_active = 1'b1;
        tick(1);
    endtask

    task automatic end_dl(output int pulses);
        int d0;
        d0 = done_cnt;
        dl_active = 1'b0;
        for (int i = 0; i < 300 && done_cnt == d0; i++) tick(1);
        tick(4);
        pulses = done_cnt - d0;
    endtask

    task automatic test_reset();
        int t0;
        ack_flip = 1'b1;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        n_checks++;
        if (port_req !== 1'b1 || words_written !== 24'd0 || dl_wait !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: req=%b ww=%0d wait=%b done=%b, required 1 0 0 0",
                     port_req, words_written, dl_wait, done);
        end
        n_checks++;
        if (port_a !== 23'd0 || port_d !== 16'd0 || port_ds !== 2'b00 || port_we !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_port: a=%h d=%h ds=%b we=%b, required 0 0 00 1",
                     port_a, port_d, port_ds, port_we);
        end
        t0 = toggles;
        tick(20);
        n_checks++;
        if (toggles !== t0 || port_req !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_quiet: toggles=%0d req=%b, required 0 toggles req=1",
                     toggles - t0, port_req);
        end
    endtask

    task automatic test_pairs();
        int p;
        logic r0;
        start_dl();
        push_exp(23'd0, 2'b11, 16'h2211);
        push_exp(23'd1, 2'b11, 16'h4433);
        send_byte(24'd0, 8'h11);
        send_byte(24'd1, 8'h22);
        r0 = port_req;
        tick(1);
        n_checks++;
        if (port_req === r0) begin
            n_errors++;
            $display("FAIL req_latency: port_req=%b one cycle after push, required %b", port_req, ~r0);
        end
        send_byte(24'd2, 8'h33);
        send_byte(24'd3, 8'h44);
        end_dl(p);
        n_checks++;
        if (p !== 1 || words_written !== 24'd2) begin
            n_errors++;
            $display("FAIL pairs_end: done pulses=%0d ww=%0d, required 1 2", p, words_written);
        end
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_errors++;
            $display("FAIL pairs_drain: %0d requests missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_single_bytes();
        int p;
        start_dl();
        push_exp(23'd2, 2'b10, 16'hAB00);
        send_byte(24'd5, 8'hAB);
        end_dl(p);
        n_checks++;
        if (p !== 1 || words_written !== 24'd1 || exp_q.size() !== 0) begin
            n_errors++;
            $display("FAIL single_odd: pulses=%0d ww=%0d pending=%0d, required 1 1 0",
                     p, words_written, exp_q.size());
        end
        start_dl();
        push_exp(23'd3, 2'b01, 16'h00CD);
        push_exp(23'd4, 2'b10, 16'hEF00);
        send_byte(24'd6, 8'hCD);
        send_byte(24'd9, 8'hEF);
        end_dl(p);
        n_checks++;
        if (p !== 1 || words_written !== 24'd2 || exp_q.size() !== 0) begin
            n_errors++;
            $display("FAIL unpaired: pulses=%0d ww=%0d pending=%0d, required 1 2 0",
                     p, words_written, exp_q.size());
        end
        start_dl();
        push_exp(23'd7, 2'b01, 16'h0066);
        send_byte(24'd14, 8'h66);
        end_dl(p);
        n_checks++;
        if (p !== 1 || words_written !== 24'd1 || exp_q.size() !== 0) begin
            n_errors++;
            $display("FAIL held_flush: pulses=%0d ww=%0d pending=%0d, required 1 1 0",
                     p, words_written, exp_q.size());
        end
    endtask

    task automatic test_back_pressure();
        int p;
        ack_hold = 1'b1;
        start_dl();
        for (int i = 0; i < 4; i++) begin
            push_exp(23'(8 + i), 2'b11, {8'(8'hA1 + 2 * i), 8'(8'hA0 + 2 * i)});
        end
        for (int i = 0; i < 4; i++) send_byte(24'(16 + i), 8'(8'hA0 + i));
        n_checks++;
        if (dl_wait !== 1'b0) begin
            n_errors++;
            $display("FAIL wait_low: dl_wait=%b at count 2, required 0", dl_wait);
        end
        send_byte(24'd20, 8'hA4);
        send_byte(24'd21, 8'hA5);
        n_checks++;
        if (dl_wait !== 1'b1) begin
            n_errors++;
            $display("FAIL wait_high: dl_wait=%b at count 3, required 1", dl_wait);
        end
        ack_hold = 1'b0;
        send_byte(24'd22, 8'hA6);
        send_byte(24'd23, 8'hA7);
        end_dl(p);
        n_checks++;
        if (p !== 1 || words_written !== 24'd4 || exp_q.size() !== 0) begin
            n_errors++;
            $display("FAIL back_pressure: pulses=%0d ww=%0d pending=%0d, required 1 4 0",
                     p, words_written, exp_q.size());
        end
    endtask

    task automatic test_base_offset();
        int p;
        int r0;
        r0 = b_reqs;
        start_dl();
        push_exp(23'd0, 2'b11, 16'hA55A);
        send_byte(24'd0, 8'h5A);
        send_byte(24'd1, 8'hA5);
        end_dl(p);
        n_checks++;
        if (b_reqs - r0 !== 1 || b_last_a !== 23'h080000 || b_last_d !== 16'hA55A) begin
            n_errors++;
            $display("FAIL base_offset: reqs=%0d a=%h d=%h, required 1 080000 a55a",
                     b_reqs - r0, b_last_a, b_last_d);
        end
        n_checks++;
        if (p !== 1 || exp_q.size() !== 0) begin
            n_errors++;
            $display("FAIL base_main: pulses=%0d pending=%0d, required 1 0", p, exp_q.size());
        end
    endtask

    task automatic test_reset_busy();
        int p;
        int s0;
        ack_hold = 1'b1;
        start_dl();
        push_exp(23'd0, 2'b11, 16'h8877);
        send_byte(24'd0, 8'h77);
        send_byte(24'd1, 8'h88);
        tick(3);
        reset = 1'b1;
        dl_active = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);
        n_checks++;
        if (port_req !== port_ack || words_written !== 24'd0 || dl_wait !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_busy: req=%b ack=%b ww=%0d wait=%b, required req==ack ww=0 wait=0",
                     port_req, port_ack, words_written, dl_wait);
        end
        s0 = req_seen;
        ack_flip = ~ack_flip;
        tick(6);
        n_checks++;
        if (words_written !== 24'd0 || req_seen !== s0 || port_req !== port_ack) begin
            n_errors++;
            $display("FAIL late_ack: ww=%0d new_reqs=%0d req=%b ack=%b, required 0 0 req==ack",
                     words_written, req_seen - s0, port_req, port_ack);
        end
        ack_hold = 1'b0;
        start_dl();
        push_exp(23'd0, 2'b11, 16'h3412);
        send_byte(24'd0, 8'h12);
        send_byte(24'd1, 8'h34);
        end_dl(p);
        n_checks++;
        if (p !== 1 || words_written !== 24'd1 || exp_q.size() !== 0) begin
            n_errors++;
            $display("FAIL after_reset: pulses=%0d ww=%0d pending=%0d, required 1 1 0",
                     p, words_written, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_pairs();
        test_single_bytes();
        test_back_pressure();
        test_base_offset();
        test_reset_busy();
        tick(5);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
